deserializer: RTL and testbench

- Downstream neighbour of the serializer.
- Collects the MSB-first bit stream from ser_data_o / ser_data_val_o back into a parallel word, with a bit-count (mod) tag.
- A frame is a contiguous run of cycles with ser_data_val_i high. A frame closes when valid drops or when DATA_W bits have been collected.
- Output feeds the parallel sink or loopback checker, in the same clock domain as the serializer.

---
 rtl/deserializer.sv | 93 +++++++++
 tb/tb_deserializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: assembles MSB-first frames into words.
// Ports: clk_i, arst_n_i, ser_data_i/ser_data_val_i in; deser_data_o/_mod_o/_val_o, err_o out.
module deserializer #(
    parameter int DATA_W  = 16,
    parameter int MOD_W   = 4,
    parameter int MIN_LEN = 3
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              err_o
);

    localparam int CNT_W = MOD_W + 1;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] word_nxt;

    // Bit position for the incoming bit while in RECV (cnt is 1..DATA_W-1).
    assign idx = CNT_W'(DATA_W - 1) - cnt;

    always_comb begin
        word_nxt = shreg;
        word_nxt[idx[MOD_W-1:0]] = ser_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state            <= IDLE;
            shreg            <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            err_o            <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ser_data_val_i) begin
                        shreg              <= '0;
                        shreg[DATA_W-1]    <= ser_data_i;
                        cnt                <= CNT_W'(1);
                        state              <= RECV;
                    end
                end
                RECV: begin
                    if (ser_data_val_i) begin
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            // Last bit of a full frame: emit at the same edge.
                            deser_data_o     <= word_nxt;
                            deser_data_mod_o <= '0;
                            deser_data_val_o <= 1'b1;
                            shreg            <= '0;
                            cnt              <= '0;
                            state            <= IDLE;
                        end else begin
                            shreg <= word_nxt;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end else begin
                        if (cnt >= CNT_W'(MIN_LEN)) begin
                            deser_data_o     <= shreg;
                            deser_data_mod_o <= cnt[MOD_W-1:0];
                            deser_data_val_o <= 1'b1;
                        end else begin
                            // Runt frame: drop it, keep previous output word.
                            err_o <= 1'b1;
                        end
                        shreg <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: directed frames plus a loopback-style run.
// Stimulus pushes expected events; a monitor pops them on each output pulse.
module tb_deserializer;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        err_o;

    deserializer #(.DATA_W(16), .MOD_W(4), .MIN_LEN(3)) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_err;
        logic [15:0] d;
        logic [3:0]  m;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_d = '0;
    logic [3:0]  last_m = '0;

    // Monitor: samples away from the active edge.
    always @(negedge clk_i) begin
        if (deser_data_val_o || err_o) begin
            checks++;
            if (deser_data_val_o && err_o) begin
                errors++;
                $display("FAIL both_pulses: val=1 err=1, required only one");
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: val=%0b err=%0b data=%h, required none",
                         deser_data_val_o, err_o, deser_data_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_err != err_o || deser_data_o !== e.d || deser_data_mod_o !== e.m) begin
                    errors++;
                    $display("FAIL frame: err=%0b data=%h mod=%0d, required err=%0b data=%h mod=%0d",
                             err_o, deser_data_o, deser_data_mod_o, e.is_err, e.d, e.m);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        ser_data_val_i = 1'b0;
        ser_data_i     = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Queue the expected result of an n-bit frame, then drive its bits.
    task automatic frame(input logic [15:0] w, input int n);
        exp_t        e;
        logic [15:0] mask;
        mask = (n >= 16) ? 16'hFFFF : ~(16'hFFFF >> n);
        if (n < 3) begin
            e.is_err = 1'b1;
            e.d      = last_d;
            e.m      = last_m;
        end else begin
            e.is_err = 1'b0;
            e.d      = w & mask;
            e.m      = 4'(n);
            last_d   = e.d;
            last_m   = e.m;
        end
        q.push_back(e);
        for (int i = 0; i < n; i++) begin
            ser_data_i     = w[15-i];
            ser_data_val_i = 1'b1;
            tick();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        #1;
        chk("reset_state", {deser_data_o, deser_data_mod_o, deser_data_val_o, err_o}, 32'h0);
        idle(2);
        arst_n_i = 1'b1;
        idle(2);

        frame(16'hA5C3, 16);
        idle(2);
        frame(16'hB000, 5);
        idle(2);
        frame(16'hC000, 2);
        idle(2);
        frame(16'h8000, 1);
        idle(1);
        frame(16'hE000, 3);
        idle(1);
        frame(16'h1235, 15);
        idle(1);
        frame(16'hFFFF, 16);
        frame(16'h0001, 16);
        idle(3);

        // Reset mid-frame: the partial frame must vanish silently.
        for (int i = 0; i < 7; i++) begin
            ser_data_i     = 1'b1;
            ser_data_val_i = 1'b1;
            tick();
        end
        arst_n_i = 1'b0;
        #1;
        chk("reset_mid_frame", {deser_data_o, deser_data_mod_o, deser_data_val_o, err_o}, 32'h0);
        last_d = '0;
        last_m = '0;
        idle(2);
        arst_n_i = 1'b1;
        idle(4);
        frame(16'h4000, 2);
        idle(2);

        for (int f = 0; f < 1000; f++) begin
            int n;
            n = int'($urandom_range(3, 16));
            frame(16'($urandom), n);
            if (n < 16 || $urandom_range(0, 1) == 1) idle(1);
        end
        idle(4);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
